// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared state encoding, hex digit constants and accumulator width rule
package mvm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLR       = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_WAIT_MAC  = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } state_e;

    localparam logic [3:0] HEX_0 = 4'h0, HEX_1 = 4'h1, HEX_2 = 4'h2, HEX_3 = 4'h3;
    localparam logic [3:0] HEX_4 = 4'h4, HEX_5 = 4'h5, HEX_6 = 4'h6, HEX_7 = 4'h7;
    localparam logic [3:0] HEX_8 = 4'h8, HEX_9 = 4'h9, HEX_A = 4'hA, HEX_B = 4'hB;
    localparam logic [3:0] HEX_C = 4'hC, HEX_D = 4'hD, HEX_E = 4'hE, HEX_F = 4'hF;

    // Products are 2*DW wide; the extra DW bits give headroom for the row sum.
    function automatic int acc_width(input int data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/timeout_ctr.sv
// rtl/timeout_ctr.sv - idle-cycle counter that flags the LIMIT-th enabled cycle since the last clear
module timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mat_vec_loader.sv
// rtl/mat_vec_loader.sv - fetches ROWS matrix rows plus one vector word over Avalon-MM, then captures MAC results
module mat_vec_loader
    import mvm_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  ROWS       = 8,
    parameter int  COLS       = 8,
    parameter int  ADDR_WIDTH = 32,
    parameter int  TIMEOUT    = 255,
    localparam int W          = COLS * DATA_WIDTH,
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH),
    localparam int SEL_WIDTH  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic [ADDR_WIDTH-1:0]     avm_address,
    output logic                      avm_read,
    input  logic [W-1:0]              avm_readdata,
    input  logic                      avm_readdatavalid,
    input  logic                      avm_waitrequest,
    output logic                      mac_clr,
    output logic                      a_wren,
    output logic                      b_wren,
    output logic [W-1:0]              row_data,
    input  logic                      mac_done,
    input  logic [ROWS*ACC_WIDTH-1:0] mac_out,
    input  logic [SEL_WIDTH-1:0]      res_sel,
    output logic [ACC_WIDTH-1:0]      res_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int              IDX_W    = $clog2(ROWS + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [W-1:0]            row_q;
    logic                    a_wren_q, b_wren_q;
    logic [ACC_WIDTH-1:0]    res_q [ROWS];
    logic                    start_ok, data_ok, tmo_en, tmo_clear, tmo_expired;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign data_ok  = (state_q == ST_WAIT_DATA) && avm_readdatavalid;
    assign tmo_en   = (state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_MAC);
    // Any state change restarts the idle count, so each wait gets a fresh budget.
    assign tmo_clear = (state_d != state_q);

    timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_CLR;
            ST_CLR:                   state_d = ST_REQ;
            ST_REQ:                   if (!avm_waitrequest) state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    state_d = (idx_q == LAST_IDX) ? ST_WAIT_MAC : ST_REQ;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_WAIT_MAC: begin
                if (mac_done) begin
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end
            end
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            row_q    <= '0;
            a_wren_q <= 1'b0;
            b_wren_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_wren_q <= data_ok && (idx_q < LAST_IDX);
            b_wren_q <= data_ok && (idx_q == LAST_IDX);
            if (start_ok) begin
                idx_q  <= '0;
                addr_q <= base_addr;
            end else if (data_ok) begin
                idx_q  <= idx_q + 1'b1;
                addr_q <= addr_q + 1'b1;
                row_q  <= avm_readdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (rst || start_ok) begin
                res_q[r] <= '0;
            end else if (state_q == ST_WAIT_MAC && mac_done) begin
                res_q[r] <= mac_out[r*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    assign avm_read    = (state_q == ST_REQ);
    assign avm_address = addr_q;
    assign mac_clr     = (state_q == ST_CLR);
    assign a_wren      = a_wren_q;
    assign b_wren      = b_wren_q;
    assign row_data    = row_q;
    assign res_data    = res_q[res_sel];
    assign busy        = (state_q == ST_CLR) || (state_q == ST_REQ) || tmo_en;
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERR);

endmodule

// File: tb/tb_mat_vec_loader.sv
// tb/tb_mat_vec_loader.sv - directed bench for mat_vec_loader (default geometry and a 4x4x16 instance)
`timescale 1ns/1ps
module tb_mat_vec_loader;

    localparam int ACC  = 24;
    localparam int ACC2 = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Instance 1: default geometry, TIMEOUT shortened to 16
    logic        start = 0, avm_read, avm_readdatavalid = 0, avm_waitrequest = 0;
    logic [31:0] base_addr = 0, avm_address;
    logic [63:0] avm_readdata = 0, row_data;
    logic        mac_clr, a_wren, b_wren, mac_done = 0, busy, done, err;
    logic [8*ACC-1:0] mac_out;
    logic [2:0]  res_sel = 0;
    logic [ACC-1:0] res_data;

    // Instance 2: ROWS=4, COLS=4, DATA_WIDTH=16
    logic        start2 = 0, avm_read2, rdv2 = 0;
    logic [31:0] base_addr2 = 0, avm_address2;
    logic [63:0] rdata2 = 0, row_data2;
    logic        mac_clr2, a_wren2, b_wren2, mac_done2 = 0, busy2, done2, err2;
    logic [4*ACC2-1:0] mac_out2;
    logic [1:0]  res_sel2 = 0;
    logic [ACC2-1:0] res_data2;

    localparam logic [ACC-1:0] EXP1 [8] = '{24'h123456, 24'h00ABCD, 24'hFFFFFF, 24'h800001,
                                            24'h0F0F0F, 24'h5A5A5A, 24'h000001, 24'hC3C3C3};
    localparam logic [ACC2-1:0] EXP2 [4] = '{48'hFFFF_0000_1234, 48'h0000_0000_0001,
                                             48'h8000_0000_0000, 48'h1234_5678_9ABC};

    mat_vec_loader #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .mac_clr(mac_clr), .a_wren(a_wren), .b_wren(b_wren), .row_data(row_data),
        .mac_done(mac_done), .mac_out(mac_out), .res_sel(res_sel), .res_data(res_data),
        .busy(busy), .done(done), .err(err)
    );

    mat_vec_loader #(.DATA_WIDTH(16), .ROWS(4), .COLS(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr2),
        .avm_address(avm_address2), .avm_read(avm_read2), .avm_readdata(rdata2),
        .avm_readdatavalid(rdv2), .avm_waitrequest(1'b0),
        .mac_clr(mac_clr2), .a_wren(a_wren2), .b_wren(b_wren2), .row_data(row_data2),
        .mac_done(mac_done2), .mac_out(mac_out2), .res_sel(res_sel2), .res_data(res_data2),
        .busy(busy2), .done(done2), .err(err2)
    );

    typedef struct {
        int n_a, n_b, n_clr, n_rd, addr_bad, data_bad, overlap, b_early, multi_rd, stuck, stalls;
        logic [31:0] last_addr;
        bit hung;
    } pass_t;

    function automatic logic [63:0] mem1(input logic [31:0] a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[k*8 +: 8] = a[7:0] ^ 8'(k * 37);
        return w;
    endfunction

    function automatic logic [63:0] mem2(input logic [31:0] a);
        logic [63:0] w;
        for (int k = 0; k < 4; k++) w[k*16 +: 16] = {a[7:0], 8'(k + 1)};
        return w;
    endfunction

    // Memory + MAC model for instance 1, stepped on falling edges.
    task automatic drive_pass(input logic [31:0] base, input int ws, input int withhold_idx,
                              input int restart_idx, output pass_t r);
        int stall = 0, rd = 0, mac_cnt = -1, pend_idx = 0;
        bit pending = 0, withheld = 0, b_seen = 0;
        logic [31:0] pend_addr = 0;
        logic [63:0] last_word = 0;
        r = '{default: 0};
        @(negedge clk);
        base_addr = base;
        start = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = 0; mac_done = 0; avm_readdatavalid = 0; avm_waitrequest = 0;
            if (done || err) break;
            if (int'(a_wren) + int'(b_wren) + int'(mac_clr) > 1) r.overlap++;
            if (avm_read && (pending || withheld)) r.multi_rd++;
            if (mac_clr) r.n_clr++;
            if (a_wren) begin
                r.n_a++;
                if (b_seen) r.b_early++;
                if (row_data !== last_word) r.data_bad++;
            end
            if (b_wren) begin
                r.n_b++; b_seen = 1; mac_cnt = 0;
                if (row_data !== last_word) r.data_bad++;
            end else if (mac_cnt >= 0) begin
                mac_cnt++;
                if (mac_cnt == 5) mac_done = 1;
            end
            if (pending) begin
                pending = 0;
                if (pend_idx == withhold_idx) withheld = 1;
                else begin
                    avm_readdatavalid = 1;
                    avm_readdata = mem1(pend_addr);
                    last_word = avm_readdata;
                end
                if (pend_idx == restart_idx) begin
                    start = 1;
                    base_addr = 32'hDEAD_0000;
                end
            end
            if (withheld) r.stuck++;
            if (avm_read) begin
                if (avm_address !== base + 32'(rd)) r.addr_bad++;
                if (stall < ws) begin
                    avm_waitrequest = 1; stall++; r.stalls++;
                end else begin
                    stall = 0; pending = 1; pend_addr = avm_address; pend_idx = rd;
                    rd++; r.last_addr = avm_address;
                end
            end
        end
        r.hung = !(done || err);
        r.n_rd = rd;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        vectors++; if (avm_read !== 1'b0) begin miscompares++; $display("FAIL reset_avm_read got=%b exp=0", avm_read); end
        vectors++; if (avm_address !== 32'h0) begin miscompares++; $display("FAIL reset_avm_address got=%h exp=0", avm_address); end
        vectors++; if ({mac_clr, a_wren, b_wren} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes got=%b exp=000", {mac_clr, a_wren, b_wren}); end
        vectors++; if ({busy, done, err} !== 3'b000) begin miscompares++; $display("FAIL reset_status got=%b exp=000", {busy, done, err}); end
        vectors++; if (row_data !== 64'h0) begin miscompares++; $display("FAIL reset_row_data got=%h exp=0", row_data); end
        vectors++; if (res_data !== 24'h0) begin miscompares++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
    endtask

    task automatic test_basic();
        pass_t r;
        drive_pass(32'h0, 0, -1, -1, r);
        vectors++; if (r.hung) begin miscompares++; $display("FAIL basic_finish got=hung exp=done"); end
        vectors++; if (r.n_a !== 8) begin miscompares++; $display("FAIL basic_a_wren got=%0d exp=8", r.n_a); end
        vectors++; if (r.n_b !== 1) begin miscompares++; $display("FAIL basic_b_wren got=%0d exp=1", r.n_b); end
        vectors++; if (r.b_early !== 0) begin miscompares++; $display("FAIL basic_order got=%0d exp=0", r.b_early); end
        vectors++; if (r.n_rd !== 9) begin miscompares++; $display("FAIL basic_reads got=%0d exp=9", r.n_rd); end
        vectors++; if (r.addr_bad !== 0) begin miscompares++; $display("FAIL basic_addr got=%0d bad exp=0", r.addr_bad); end
        vectors++; if (r.data_bad !== 0) begin miscompares++; $display("FAIL basic_row_data got=%0d bad exp=0", r.data_bad); end
        vectors++; if (r.n_clr !== 1) begin miscompares++; $display("FAIL basic_mac_clr got=%0d exp=1", r.n_clr); end
        vectors++; if (r.overlap + r.multi_rd !== 0) begin miscompares++; $display("FAIL basic_exclusive got=%0d exp=0", r.overlap + r.multi_rd); end
        vectors++; if ({busy, done, err} !== 3'b010) begin miscompares++; $display("FAIL basic_status got=%b exp=010", {busy, done, err}); end
        for (int i = 0; i < 8; i++) begin
            res_sel = 3'(i);
            #1;
            vectors++; if (res_data !== EXP1[i]) begin miscompares++; $display("FAIL basic_res_%0d got=%h exp=%h", i, res_data, EXP1[i]); end
        end
    endtask

    task automatic test_waitreq();
        pass_t r;
        drive_pass(32'h0, 3, -1, -1, r);
        vectors++; if (r.stalls !== 27) begin miscompares++; $display("FAIL wait_stalls got=%0d exp=27", r.stalls); end
        vectors++; if (r.addr_bad !== 0) begin miscompares++; $display("FAIL wait_addr_stable got=%0d bad exp=0", r.addr_bad); end
        vectors++; if (r.n_a !== 8 || r.n_b !== 1) begin miscompares++; $display("FAIL wait_wren got=%0d/%0d exp=8/1", r.n_a, r.n_b); end
        vectors++; if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL wait_status got=%b exp=10", {done, err}); end
    endtask

    task automatic test_wrap();
        pass_t r;
        drive_pass(32'hFFFF_FFFC, 0, -1, -1, r);
        vectors++; if (r.addr_bad !== 0) begin miscompares++; $display("FAIL wrap_addr got=%0d bad exp=0", r.addr_bad); end
        vectors++; if (r.last_addr !== 32'h4) begin miscompares++; $display("FAIL wrap_last_addr got=%h exp=00000004", r.last_addr); end
        vectors++; if (row_data !== mem1(32'h4)) begin miscompares++; $display("FAIL wrap_row_data got=%h exp=%h", row_data, mem1(32'h4)); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got=%b exp=1", done); end
    endtask

    task automatic test_start_ignored();
        pass_t r;
        drive_pass(32'h20, 0, -1, 2, r);
        vectors++; if (r.n_clr !== 1) begin miscompares++; $display("FAIL restart_mac_clr got=%0d exp=1", r.n_clr); end
        vectors++; if (r.addr_bad !== 0) begin miscompares++; $display("FAIL restart_addr got=%0d bad exp=0", r.addr_bad); end
        vectors++; if (r.n_a !== 8 || r.n_b !== 1 || done !== 1'b1) begin miscompares++; $display("FAIL restart_pass got=%0d/%0d done=%b exp=8/1 done=1", r.n_a, r.n_b, done); end
    endtask

    task automatic test_timeout();
        pass_t r;
        drive_pass(32'h40, 0, 3, -1, r);
        vectors++; if ({busy, done, err} !== 3'b001) begin miscompares++; $display("FAIL tmo_status got=%b exp=001", {busy, done, err}); end
        vectors++; if (r.stuck !== 16) begin miscompares++; $display("FAIL tmo_cycles got=%0d exp=16", r.stuck); end
        vectors++; if (r.n_a !== 3 || r.n_b !== 0) begin miscompares++; $display("FAIL tmo_wren got=%0d/%0d exp=3/0", r.n_a, r.n_b); end
        vectors++; if (r.n_rd !== 4) begin miscompares++; $display("FAIL tmo_reads got=%0d exp=4", r.n_rd); end
        res_sel = 3'd0;
        #1;
        vectors++; if (res_data !== 24'h0) begin miscompares++; $display("FAIL tmo_no_capture got=%h exp=0", res_data); end
    endtask

    task automatic test_recover();
        pass_t r;
        drive_pass(32'h80, 0, -1, -1, r);
        vectors++; if ({busy, done, err} !== 3'b010) begin miscompares++; $display("FAIL recover_status got=%b exp=010", {busy, done, err}); end
        vectors++; if (r.n_a !== 8 || r.n_b !== 1 || r.addr_bad !== 0) begin miscompares++; $display("FAIL recover_pass got=%0d/%0d addr_bad=%0d exp=8/1/0", r.n_a, r.n_b, r.addr_bad); end
    endtask

    task automatic test_reset_midpass();
        int bad = 0;
        @(negedge clk); base_addr = 32'h10; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if ({busy, avm_read} !== 2'b10) begin miscompares++; $display("FAIL midpass_wait_data got=%b exp=10", {busy, avm_read}); end
        rst = 1;
        @(negedge clk); rst = 0; avm_readdatavalid = 1; avm_readdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk); avm_readdatavalid = 0;
        for (int i = 0; i < 3; i++) begin
            if (avm_read || avm_address != 0 || mac_clr || a_wren || b_wren || busy || done || err || row_data != 0) bad++;
            @(negedge clk);
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL midpass_reset_values got=%0d bad cycles exp=0", bad); end
        res_sel = 3'd2;
        #1;
        vectors++; if (res_data !== 24'h0) begin miscompares++; $display("FAIL midpass_res_cleared got=%h exp=0", res_data); end
    endtask

    task automatic test_small();
        int na = 0, nb = 0, nrd = 0, bad = 0, mac_cnt = -1;
        bit pending = 0;
        logic [31:0] paddr = 0;
        @(negedge clk); base_addr2 = 32'h100; start2 = 1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            start2 = 0; rdv2 = 0; mac_done2 = 0;
            if (done2 || err2) break;
            if (a_wren2) na++;
            if (b_wren2) begin
                nb++; mac_cnt = 0;
                if (row_data2 !== mem2(32'h104)) bad++;
            end else if (mac_cnt >= 0) begin
                mac_cnt++;
                if (mac_cnt == 5) mac_done2 = 1;
            end
            if (pending) begin rdv2 = 1; rdata2 = mem2(paddr); pending = 0; end
            if (avm_read2) begin
                if (avm_address2 !== 32'h100 + 32'(nrd)) bad++;
                pending = 1; paddr = avm_address2; nrd++;
            end
        end
        vectors++; if (nrd !== 5) begin miscompares++; $display("FAIL small_reads got=%0d exp=5", nrd); end
        vectors++; if (na !== 4 || nb !== 1) begin miscompares++; $display("FAIL small_wren got=%0d/%0d exp=4/1", na, nb); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL small_addr_data got=%0d bad exp=0", bad); end
        vectors++; if ({done2, err2} !== 2'b10) begin miscompares++; $display("FAIL small_status got=%b exp=10", {done2, err2}); end
        for (int i = 0; i < 4; i++) begin
            res_sel2 = 2'(i);
            #1;
            vectors++; if (res_data2 !== EXP2[i]) begin miscompares++; $display("FAIL small_res_%0d got=%h exp=%h", i, res_data2, EXP2[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mac_out[i*ACC +: ACC] = EXP1[i];
        for (int i = 0; i < 4; i++) mac_out2[i*ACC2 +: ACC2] = EXP2[i];
        test_reset();
        test_basic();
        test_waitreq();
        test_wrap();
        test_start_ignored();
        test_timeout();
        test_recover();
        test_reset_midpass();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mat_vec_loader.md
MAT_VEC_LOADER -- requirements
Module: mat_vec_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 Parameter ROWS, default 8, matrix rows; also the number of results.
REQ-003 Parameter COLS, default 8, elements per memory word; word width W = COLS*DATA_WIDTH.
REQ-004 Parameter ADDR_WIDTH, default 32, word address width.
REQ-005 Parameter TIMEOUT, default 255, maximum idle cycles allowed while waiting for data or for the MAC.
REQ-006 Derived ACC_WIDTH = 3*DATA_WIDTH; SEL_WIDTH = clog2(ROWS).
REQ-007 clk  in  1  sole clock; all logic on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  single-cycle request to begin a load-and-compute pass.
REQ-010 base_addr  in  ADDR_WIDTH  word address of matrix row 0; sampled when start is accepted.
REQ-011 avm_address  out  ADDR_WIDTH  Avalon-MM read address.
REQ-012 avm_read  out  1  Avalon-MM read request.
REQ-013 avm_readdata  in  W  read data; element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 avm_readdatavalid  in  1  read data valid.
REQ-015 avm_waitrequest  in  1  slave stall.
REQ-016 mac_clr  out  1  clears the MAC array.
REQ-017 a_wren  out  1  pushes row_data into the matrix FIFOs.
REQ-018 b_wren  out  1  pushes row_data into the vector FIFO.
REQ-019 row_data  out  W  registered copy of the last word received.
REQ-020 mac_done  in  1  MAC array has finished.
REQ-021 mac_out  in  ROWS*ACC_WIDTH  MAC results; row r occupies [r*ACC_WIDTH +: ACC_WIDTH].
REQ-022 res_sel  in  SEL_WIDTH  selects the result to read out.
REQ-023 res_data  out  ACC_WIDTH  captured result for row res_sel (combinational read of the result registers).
REQ-024 busy  out  1  pass in progress.
REQ-025 done  out  1  pass completed successfully.
REQ-026 err  out  1  pass aborted by timeout.

Function
REQ-027 The block SHALL implement states IDLE, CLR, REQ, WAIT_DATA, WAIT_MAC, DONE and ERR.
REQ-028 IDLE/DONE/ERR + start: latch base_addr, reset the index to 0, clear the result registers, go to CLR; start in any other state SHALL be ignored.
REQ-029 CLR: assert mac_clr for exactly one cycle, then go to REQ.
REQ-030 REQ: drive avm_read=1 and avm_address=base+idx, holding both stable while avm_waitrequest=1; on a cycle with avm_waitrequest=0, go to WAIT_DATA with avm_read=0 in the following cycle.
REQ-031 The block SHALL keep at most one read outstanding at any time.
REQ-032 WAIT_DATA + avm_readdatavalid: register the word into row_data; one cycle later pulse a_wren if idx<ROWS, or b_wren if idx==ROWS; increment idx.
REQ-033 After the word with idx==ROWS is received (ROWS+1 reads in total), go to WAIT_MAC; otherwise return to REQ.
REQ-034 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-035 WAIT_MAC + mac_done: capture all ROWS results from mac_out into the result registers, then go to DONE.
REQ-036 done SHALL be 1 in DONE only; err SHALL be 1 in ERR only; busy SHALL be 1 in CLR, REQ, WAIT_DATA and WAIT_MAC.
REQ-037 The timeout counter SHALL reset on every state entry and count cycles spent in WAIT_DATA or WAIT_MAC; on reaching TIMEOUT, go to ERR, with no FIFO write and no capture.
REQ-038 Cycles stalled in REQ by waitrequest SHALL NOT count toward the timeout.
REQ-039 a_wren, b_wren and mac_clr SHALL never be asserted in the same cycle.
REQ-040 avm_readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-041 When mac_done and a timeout expiry occur in the same cycle, mac_done SHALL win.

Reset
REQ-042 On rst=1 at a clock edge: state=IDLE, idx=0, timeout counter=0, result registers=0, row_data=0.
REQ-043 Reset values: avm_read=0, avm_address=0, mac_clr=0, a_wren=0, b_wren=0, busy=0, done=0, err=0.
REQ-044 Reset mid-pass SHALL abandon the outstanding read; a late avm_readdatavalid after reset SHALL be ignored.

Structure
REQ-045 The state enum, HEX digit constants and the ACC_WIDTH derivation rule SHALL live in a shared package, mvm_pkg.
REQ-046 The timeout counter SHALL be a sub-module, timeout_ctr, with clear, enable and expired signals.

Verification
REQ-047 Defaults, base_addr=0, zero-wait memory, mac_done 5 cycles after b_wren: exactly 8 a_wren pulses, then 1 b_wren; addresses 0..8; done=1; res_data matches mac_out for res_sel 0..7.
REQ-048 waitrequest held 3 cycles on every read: address stays stable during each stall; no timeout; sequence identical to REQ-047.
REQ-049 base_addr=0xFFFFFFFC: addresses 0xFFFFFFFC..0xFFFFFFFF, then 0x0..0x4.
REQ-050 TIMEOUT=16 and readdatavalid withheld on read 3: err=1 after 16 cycles in WAIT_DATA; only 3 a_wren pulses; busy=0; a following start runs a clean pass.
REQ-051 start pulsed during WAIT_DATA: ignored; rst asserted mid-pass, then a stray readdatavalid: all outputs at reset values, no wren.
REQ-052 ROWS=4, COLS=4, DATA_WIDTH=16: 5 reads; ACC_WIDTH=48; results captured correctly.
